charge_sequencer: RTL and testbench
===================================

CHARGE_SEQUENCER -- requirements
Module: charge_sequencer

Interface
REQ-001 Parameter VCUTOFF, default 10'd600, is the 3.0 V trickle-to-CC threshold (vbat code, LSB 5 mV).
REQ-002 Parameter VTARGET, default 10'd840, is the 4.2 V CC-to-CV threshold and the CV regulation setpoint.
REQ-003 Parameter VRECHG, default 10'd800, is the 4.0 V recharge threshold applied in DONE.
REQ-004 Parameters TEMP_LO and TEMP_HI, defaults 8'd37 and 8'd92, bound the valid temperature window (0–0.5 V scale mapped to -40..125 C).
REQ-005 Parameter DEB, default 4, is the number of consecutive qualifying samples required for any transition.
REQ-006 Parameter TOUT, default 16'd50000, is the CV timeout in samples.
REQ-007 Port clk: input, 1 bit, single clock; all state changes occur on its rising edge.
REQ-008 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-009 Port en: input, 1 bit, charge enable.
REQ-010 Port sel: input, 4 bits, capacity select; capacity = 50 mAh × (sel+1).
REQ-011 Port smp_vld: input, 1 bit, one-cycle strobe marking vbat_code, ibat_code and temp_code as valid.
REQ-012 Port vbat_code: input, 10 bits, battery voltage code.
REQ-013 Port ibat_code: input, 8 bits, battery current code (LSB 5 mA).
REQ-014 Port temp_code: input, 8 bits, battery temperature code.
REQ-015 Port tc, cc, cv: output, 1 bit each, one-hot mode flags.
REQ-016 Port iset_code: output, 8 bits, current setpoint (LSB 5 mA).
REQ-017 Port vset_code: output, 10 bits, voltage setpoint.
REQ-018 Port done: output, 1 bit, charge complete.
REQ-019 Port fault: output, 1 bit, temperature or timeout fault.

Function
REQ-020 The block SHALL implement states IDLE, TC, CC, CV, DONE and FAULT, with every output registered.
REQ-021 In IDLE, on en=1, the block SHALL latch sel into cap (4 bits) and enter TC on the next cycle; sel changes after the latch SHALL be ignored until the next return to IDLE.
REQ-022 TC SHALL drive tc=1, iset_code=cap+1 (0.1C) and vset_code=VTARGET.
REQ-023 CC SHALL drive cc=1, iset_code=10×(cap+1) (1C; 160 maximum, no overflow) and vset_code=VTARGET.
REQ-024 CV SHALL drive cv=1, iset_code=10×(cap+1) as a limit and vset_code=VTARGET.
REQ-025 IDLE, DONE and FAULT SHALL drive tc=cc=cv=0 and iset_code=0.
REQ-026 Conditions SHALL be evaluated only on smp_vld cycles; a 3-bit debounce counter SHALL increment on each qualifying sample, clear on each non-qualifying sample or state change, and fire the transition on the sample where it reaches DEB.
REQ-027 Transition latency SHALL be one cycle: outputs change on the clk edge following the DEB-th qualifying smp_vld.
REQ-028 TC→CC SHALL occur when vbat_code ≥ VCUTOFF.
REQ-029 CC→CV SHALL occur when vbat_code ≥ VTARGET.
REQ-030 CV→DONE SHALL occur when ibat_code ≤ cap+1 (0.1C termination).
REQ-031 DONE→TC SHALL occur when vbat_code < VCUTOFF; otherwise DONE→CC SHALL occur when vbat_code < VRECHG.
REQ-032 A temperature fault SHALL occur in TC, CC or CV when temp_code < TEMP_LO or > TEMP_HI for DEB consecutive samples, with its own debounce counter, and SHALL move the block to FAULT.
REQ-033 A 16-bit CV timer SHALL clear on CV entry and count samples; at TOUT the block SHALL go to FAULT.
REQ-034 Priority SHALL be en=0 > temperature fault > timeout > normal transition.
REQ-035 en=0 in any state SHALL return the block to IDLE on the next edge with all counters cleared.
REQ-036 FAULT SHALL hold fault=1 until en=0.
REQ-037 done SHALL equal 1 only in DONE.
REQ-038 Exactly one of tc, cc and cv SHALL be high in TC/CC/CV, and none elsewhere.

Reset
REQ-039 While rst_n=0, state SHALL be IDLE with tc=cc=cv=done=fault=0, iset_code=0, vset_code=0, cap=0 and all counters at 0.
REQ-040 Release of rst_n SHALL take effect on the first clk edge, and reset applied mid-charge SHALL abort immediately without completing any pending transition.

Verification
REQ-041 sel=8, en=1, vbat=500 → TC with iset=9; then 4 samples at vbat=620 → CC with iset=90 one cycle after the 4th smp_vld.
REQ-042 In CC, samples at vbat 845,845,830,845,845,845,845 → CV entered only after the last sample (counter reset by 830).
REQ-043 In CV with ibat falling to 9 for 4 samples → DONE with done=1 and iset=0; then vbat=790 for 4 samples → CC.
REQ-044 In CC, temp_code=100 for 4 samples together with a qualifying CV condition → FAULT (temperature priority); en=0 → IDLE with fault=0.
REQ-045 In CV with TOUT=10 and ibat held at 50 → FAULT after the 10th sample.
REQ-046 sel=15 → CC iset=160; rst_n pulse mid-CC → all outputs 0 asynchronously; sel changed mid-CC → iset unchanged.

Source files
------------

// File: rtl/charge_sequencer_if.sv
// Handshake bundle for the charge sequencer: sampled ADC codes and enables in,
// registered mode flags and setpoints out.
interface charge_sequencer_if;
    logic       en;
    logic [3:0] sel;
    logic       smp_vld;
    logic [9:0] vbat_code;
    logic [7:0] ibat_code;
    logic [7:0] temp_code;
    logic       tc;
    logic       cc;
    logic       cv;
    logic [7:0] iset_code;
    logic [9:0] vset_code;
    logic       done;
    logic       fault;

    // Controller side: drives enable, capacity select and samples.
    modport master (
        output en, sel, smp_vld, vbat_code, ibat_code, temp_code,
        input  tc, cc, cv, iset_code, vset_code, done, fault
    );

    // Sequencer side.
    modport slave (
        input  en, sel, smp_vld, vbat_code, ibat_code, temp_code,
        output tc, cc, cv, iset_code, vset_code, done, fault
    );
endinterface

// File: rtl/charge_sequencer.sv
// Li-ion charge sequencer: trickle -> constant current -> constant voltage -> done,
// with debounced transitions, temperature window fault and CV timeout.
module charge_sequencer #(
    parameter logic [9:0]  VCUTOFF = 10'd600,
    parameter logic [9:0]  VTARGET = 10'd840,
    parameter logic [9:0]  VRECHG  = 10'd800,
    parameter logic [7:0]  TEMP_LO = 8'd37,
    parameter logic [7:0]  TEMP_HI = 8'd92,
    parameter int unsigned DEB     = 4,
    parameter logic [15:0] TOUT    = 16'd50000
) (
    input logic               clk,
    input logic               rst_n,
    charge_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StTc,
        StCc,
        StCv,
        StDone,
        StFault
    } state_e;

    localparam logic [3:0] DebCnt = 4'(DEB);

    state_e      state_q, state_d;
    logic [3:0]  cap_q, cap_d;
    logic [2:0]  dbn_q, dbn_d;
    logic [2:0]  tmp_q, tmp_d;
    logic [15:0] tmr_q, tmr_d;

    logic        tc_d, cc_d, cv_d, done_d, fault_d;
    logic [7:0]  iset_d;
    logic [9:0]  vset_d;

    logic [3:0]  dbn_inc, tmp_inc;
    logic [15:0] tmr_inc;
    logic [7:0]  cap_q_p1, cap_d_p1, iset_1c;
    logic        temp_bad, qual;
    state_e      fwd_state;

    assign dbn_inc  = {1'b0, dbn_q} + 4'd1;
    assign tmp_inc  = {1'b0, tmp_q} + 4'd1;
    assign tmr_inc  = tmr_q + 16'd1;
    assign cap_q_p1 = {4'd0, cap_q} + 8'd1;
    assign cap_d_p1 = {4'd0, cap_d} + 8'd1;
    // (cap+1) is at most 16, so 10x fits in 8 bits.
    assign iset_1c  = cap_d_p1 * 8'd10;
    assign temp_bad = (bus.temp_code < TEMP_LO) || (bus.temp_code > TEMP_HI);

    // Per-state qualifying condition for the normal forward transition.
    always_comb begin
        qual      = 1'b0;
        fwd_state = state_q;
        unique case (state_q)
            StTc: begin
                qual      = bus.vbat_code >= VCUTOFF;
                fwd_state = StCc;
            end
            StCc: begin
                qual      = bus.vbat_code >= VTARGET;
                fwd_state = StCv;
            end
            StCv: begin
                qual      = bus.ibat_code <= cap_q_p1;
                fwd_state = StDone;
            end
            StDone: begin
                qual      = bus.vbat_code < VRECHG;
                fwd_state = (bus.vbat_code < VCUTOFF) ? StTc : StCc;
            end
            default: begin
                qual      = 1'b0;
                fwd_state = state_q;
            end
        endcase
    end

    // Next state and counters; priority is en=0, temperature, timeout, normal.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        dbn_d   = dbn_q;
        tmp_d   = tmp_q;
        tmr_d   = tmr_q;
        if (!bus.en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cap_d   = bus.sel;
                    state_d = StTc;
                end
                StTc, StCc, StCv: begin
                    if (bus.smp_vld) begin
                        tmp_d = temp_bad ? tmp_inc[2:0] : 3'd0;
                        dbn_d = qual ? dbn_inc[2:0] : 3'd0;
                        if (state_q == StCv) tmr_d = tmr_inc;
                        if (temp_bad && (tmp_inc == DebCnt)) begin
                            state_d = StFault;
                        end else if ((state_q == StCv) && (tmr_inc == TOUT)) begin
                            state_d = StFault;
                        end else if (qual && (dbn_inc == DebCnt)) begin
                            state_d = fwd_state;
                        end
                    end
                end
                StDone: begin
                    if (bus.smp_vld) begin
                        dbn_d = qual ? dbn_inc[2:0] : 3'd0;
                        if (qual && (dbn_inc == DebCnt)) state_d = fwd_state;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        // Every debounce and timer restarts from zero in a new state.
        if (!bus.en || (state_d != state_q)) begin
            dbn_d = 3'd0;
            tmp_d = 3'd0;
            tmr_d = 16'd0;
        end
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        tc_d    = 1'b0;
        cc_d    = 1'b0;
        cv_d    = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        iset_d  = 8'd0;
        vset_d  = 10'd0;
        unique case (state_d)
            StTc: begin
                tc_d   = 1'b1;
                iset_d = cap_d_p1;
                vset_d = VTARGET;
            end
            StCc: begin
                cc_d   = 1'b1;
                iset_d = iset_1c;
                vset_d = VTARGET;
            end
            StCv: begin
                cv_d   = 1'b1;
                iset_d = iset_1c;
                vset_d = VTARGET;
            end
            StDone:  done_d  = 1'b1;
            StFault: fault_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cap_q         <= 4'd0;
            dbn_q         <= 3'd0;
            tmp_q         <= 3'd0;
            tmr_q         <= 16'd0;
            bus.tc        <= 1'b0;
            bus.cc        <= 1'b0;
            bus.cv        <= 1'b0;
            bus.done      <= 1'b0;
            bus.fault     <= 1'b0;
            bus.iset_code <= 8'd0;
            bus.vset_code <= 10'd0;
        end else begin
            state_q       <= state_d;
            cap_q         <= cap_d;
            dbn_q         <= dbn_d;
            tmp_q         <= tmp_d;
            tmr_q         <= tmr_d;
            bus.tc        <= tc_d;
            bus.cc        <= cc_d;
            bus.cv        <= cv_d;
            bus.done      <= done_d;
            bus.fault     <= fault_d;
            bus.iset_code <= iset_d;
            bus.vset_code <= vset_d;
        end
    end

endmodule

// File: tb/tb_charge_sequencer.sv
// Bench for charge_sequencer: directed scenarios then biased random samples,
// all compared against a rule-level model of the charge profile.
module tb_charge_sequencer;

    localparam int VCUT  = 600;
    localparam int VTGT  = 840;
    localparam int VRCH  = 800;
    localparam int TLO   = 37;
    localparam int THI   = 92;
    localparam int NDEB  = 4;
    localparam int NTOUT = 10;

    localparam int M_IDLE  = 0;
    localparam int M_TC    = 1;
    localparam int M_CC    = 2;
    localparam int M_CV    = 3;
    localparam int M_DONE  = 4;
    localparam int M_FAULT = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    charge_sequencer_if bus ();

    charge_sequencer #(
        .VCUTOFF(10'd600),
        .VTARGET(10'd840),
        .VRECHG (10'd800),
        .TEMP_LO(8'd37),
        .TEMP_HI(8'd92),
        .DEB    (4),
        .TOUT   (16'd10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: charge phase plus run lengths of qualifying / hot samples.
    int m_st, m_cap, m_run, m_hot, m_cvsmp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {9'd0, bus.tc, bus.cc, bus.cv, bus.done, bus.fault, bus.iset_code, bus.vset_code};
    endfunction

    function automatic logic [31:0] exp_vec();
        int tc, cc, cv, dn, ft, iset, vset;
        tc = 0; cc = 0; cv = 0; dn = 0; ft = 0; iset = 0; vset = 0;
        case (m_st)
            M_TC:    begin tc = 1; iset = m_cap + 1;        vset = VTGT; end
            M_CC:    begin cc = 1; iset = 10 * (m_cap + 1); vset = VTGT; end
            M_CV:    begin cv = 1; iset = 10 * (m_cap + 1); vset = VTGT; end
            M_DONE:  dn = 1;
            M_FAULT: ft = 1;
            default: ;
        endcase
        return 32'((tc << 22) | (cc << 21) | (cv << 20) | (dn << 19) | (ft << 18) |
                   (iset << 10) | vset);
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_cap = 0; m_run = 0; m_hot = 0; m_cvsmp = 0;
    endtask

    // One clock of the charge profile, evaluated from the sampled inputs.
    task automatic model_step();
        int  nx, vb, ib, tp;
        bit  hot, good;
        nx = m_st;
        vb = int'(bus.vbat_code);
        ib = int'(bus.ibat_code);
        tp = int'(bus.temp_code);
        if (!bus.en) begin
            nx = M_IDLE;
        end else if (m_st == M_IDLE) begin
            m_cap = int'(bus.sel);
            nx = M_TC;
        end else if (bus.smp_vld && m_st >= M_TC && m_st <= M_CV) begin
            hot  = (tp < TLO) || (tp > THI);
            good = (m_st == M_TC) ? (vb >= VCUT) :
                   (m_st == M_CC) ? (vb >= VTGT) : (ib <= m_cap + 1);
            m_hot = hot ? m_hot + 1 : 0;
            m_run = good ? m_run + 1 : 0;
            if (m_st == M_CV) m_cvsmp++;
            if (m_hot == NDEB) nx = M_FAULT;
            else if (m_st == M_CV && m_cvsmp == NTOUT) nx = M_FAULT;
            else if (m_run == NDEB) nx = m_st + 1;
        end else if (bus.smp_vld && m_st == M_DONE) begin
            m_run = (vb < VRCH) ? m_run + 1 : 0;
            if (m_run == NDEB) nx = (vb < VCUT) ? M_TC : M_CC;
        end
        if (nx != m_st || !bus.en) begin
            m_run = 0; m_hot = 0; m_cvsmp = 0;
        end
        m_st = nx;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", obs_vec(), exp_vec());
    endtask

    task automatic samples(input int vb, input int n);
        bus.vbat_code = 10'(vb);
        bus.smp_vld   = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        int seq042 [7] = '{845, 845, 830, 845, 845, 845, 845};
        int r;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.sel = 4'd0; bus.smp_vld = 1'b0;
        bus.vbat_code = 10'd500; bus.ibat_code = 8'd100; bus.temp_code = 8'd60;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs_vec(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Trickle entry and TC->CC after four qualifying samples.
        bus.sel = 4'd8; bus.en = 1'b1; bus.vbat_code = 10'd500;
        tick();
        check("tc_flag", 32'(bus.tc), 32'd1);
        check("tc_iset", 32'(bus.iset_code), 32'd9);
        check("tc_vset", 32'(bus.vset_code), 32'd840);
        samples(620, 3);
        check("tc_hold", 32'(bus.tc), 32'd1);
        samples(620, 1);
        check("cc_flag", 32'(bus.cc), 32'd1);
        check("cc_iset", 32'(bus.iset_code), 32'd90);

        // A dip below target restarts the debounce.
        for (int i = 0; i < 7; i++) begin
            samples(seq042[i], 1);
            if (i == 5) check("cc_debounce", 32'(bus.cv), 32'd0);
        end
        check("cv_flag", 32'(bus.cv), 32'd1);

        // Termination and recharge back into CC.
        bus.ibat_code = 8'd9;
        samples(845, 4);
        check("done_flag", 32'(bus.done), 32'd1);
        check("done_iset", 32'(bus.iset_code), 32'd0);
        bus.ibat_code = 8'd100;
        samples(790, 4);
        check("recharge_cc", 32'(bus.cc), 32'd1);

        // Hot battery beats the concurrent CC->CV condition.
        bus.temp_code = 8'd100;
        samples(845, 4);
        check("temp_fault", 32'(bus.fault), 32'd1);
        check("temp_no_cv", 32'(bus.cv), 32'd0);
        bus.en = 1'b0;
        tick();
        check("fault_clear", obs_vec(), 32'd0);
        bus.temp_code = 8'd60;

        // CV timeout.
        bus.en = 1'b1; bus.smp_vld = 1'b0;
        tick();
        samples(620, 4);
        samples(845, 4);
        check("cv_again", 32'(bus.cv), 32'd1);
        bus.ibat_code = 8'd50;
        samples(845, 9);
        check("cv_pre_tout", 32'(bus.cv), 32'd1);
        samples(845, 1);
        check("tout_fault", 32'(bus.fault), 32'd1);

        // Full-scale capacity, latched select, async abort.
        bus.en = 1'b0; bus.ibat_code = 8'd100;
        tick();
        bus.sel = 4'd15; bus.en = 1'b1; bus.smp_vld = 1'b0;
        tick();
        samples(620, 4);
        check("cc_iset_max", 32'(bus.iset_code), 32'd160);
        bus.sel = 4'd3; bus.smp_vld = 1'b0;
        repeat (3) tick();
        check("sel_ignored", 32'(bus.iset_code), 32'd160);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs_vec(), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("relatch_iset", 32'(bus.iset_code), 32'd4);

        // Random phase; values biased towards the next threshold so all
        // phases get visited.
        for (int c = 0; c < 4000; c++) begin
            bus.en      = ($urandom_range(0, 79) != 0);
            bus.sel     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : bus.sel;
            bus.smp_vld = ($urandom_range(0, 3) != 0);
            bus.temp_code = ($urandom_range(0, 11) == 0) ?
                            (($urandom_range(0, 1) != 0) ? 8'($urandom_range(93, 255))
                                                         : 8'($urandom_range(0, 36)))
                            : 8'($urandom_range(37, 92));
            r = $urandom_range(0, 3);
            case (m_st)
                M_TC:    bus.vbat_code = (r != 0) ? 10'($urandom_range(600, 700))
                                                  : 10'($urandom_range(450, 599));
                M_CC:    bus.vbat_code = (r != 0) ? 10'($urandom_range(840, 860))
                                                  : 10'($urandom_range(700, 839));
                M_DONE:  bus.vbat_code = (r != 0) ? 10'($urandom_range(500, 799))
                                                  : 10'($urandom_range(800, 850));
                default: bus.vbat_code = 10'($urandom_range(500, 900));
            endcase
            bus.ibat_code = (r != 0) ? 8'($urandom_range(0, m_cap + 1))
                                     : 8'($urandom_range(0, 200));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
